// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared widths, FSM encoding and circle selects for the laser scan sequencer
package laser_pkg;

    localparam int LASER_CW = 4;
    localparam int LASER_NW = 6;
    localparam int GRID_N   = 2 ** LASER_CW;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SCAN     = 2'd1;
    localparam logic [1:0] ST_PASS_END = 2'd2;
    localparam logic [1:0] ST_FIN      = 2'd3;

    localparam logic SEL_C1 = 1'b0;
    localparam logic SEL_C2 = 1'b1;

endpackage

// File: rtl/laser_best_tracker.sv
// rtl/laser_best_tracker.sv - running maximum of evaluator counts; ties move to the later raster index
module laser_best_tracker
    import laser_pkg::*;
#(
    parameter int CW = LASER_CW,
    parameter int NW = LASER_NW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            rsp_valid,
    input  logic [NW-1:0]   rsp_cnt,
    input  logic [2*CW-1:0] rsp_idx,
    output logic [NW-1:0]   best_cnt,
    output logic [2*CW-1:0] best_idx
);

    logic [NW-1:0]   cnt_q, cnt_d;
    logic [2*CW-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (rsp_valid && (rsp_cnt >= cnt_q)) begin
            cnt_d = rsp_cnt;
            idx_d = rsp_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign best_cnt = cnt_q;
    assign best_idx = idx_q;

endmodule

// File: rtl/laser_scan_ctrl.sv
// rtl/laser_scan_ctrl.sv - raster-scan pass sequencer alternating the moving circle until convergence
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int CW       = LASER_CW,
    parameter int NW       = LASER_NW,
    parameter int MAX_OUT  = 4,
    parameter int MAX_PASS = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          REQ_VALID,
    input  logic          REQ_READY,
    output logic [CW-1:0] REQ_CX,
    output logic [CW-1:0] REQ_CY,
    output logic          REQ_FEN,
    output logic [CW-1:0] REQ_FX,
    output logic [CW-1:0] REQ_FY,
    input  logic          RSP_VALID,
    input  logic [NW-1:0] RSP_CNT,
    output logic [CW-1:0] C1X,
    output logic [CW-1:0] C1Y,
    output logic [CW-1:0] C2X,
    output logic [CW-1:0] C2Y,
    output logic [NW-1:0] TOTAL,
    output logic          BUSY,
    output logic          DONE,
    output logic          PROTO_ERR
);

    localparam int             IW        = 2 * CW + 1;
    localparam logic [IW-1:0]  IDX_END   = {1'b1, {(2 * CW){1'b0}}};
    localparam logic [IW-1:0]  IDX_LAST  = IDX_END - IW'(1);
    localparam logic [2:0]     OUT_LIM   = 3'(MAX_OUT);
    localparam logic [3:0]     LAST_PASS = 4'(MAX_PASS - 1);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   issue_q, issue_d;
    logic [IW-1:0]   rspi_q, rspi_d;
    logic [2:0]      outst_q, outst_d;
    logic [3:0]      pass_q, pass_d;
    logic            sel_q, sel_d;
    logic [2*CW-1:0] c1_q, c1_d;
    logic [2*CW-1:0] c2_q, c2_d;
    logic [2*CW-1:0] fix_q, fix_d;
    logic            fen_q, fen_d;
    logic [NW-1:0]   total_q, total_d;
    logic            perr_q, perr_d;

    logic            rsp_ok;
    logic            stray;
    logic            req_valid;
    logic            fire;
    logic            clear_best;
    logic [NW-1:0]   best_cnt;
    logic [2*CW-1:0] best_idx;
    logic [2*CW-1:0] old_c;
    logic            converged;

    // Responses only count while scanning with something actually in flight.
    assign rsp_ok    = RSP_VALID && (state_q == ST_SCAN) && (outst_q != 3'd0);
    assign stray     = RSP_VALID && !rsp_ok;
    assign req_valid = (state_q == ST_SCAN) && (issue_q < IDX_END)
                       && ((outst_q < OUT_LIM) || rsp_ok);
    assign fire      = req_valid && REQ_READY;

    laser_best_tracker #(.CW(CW), .NW(NW)) u_best (
        .clk       (CLK),
        .rst       (RST),
        .clear     (clear_best),
        .rsp_valid (rsp_ok),
        .rsp_cnt   (RSP_CNT),
        .rsp_idx   (rspi_q[2*CW-1:0]),
        .best_cnt  (best_cnt),
        .best_idx  (best_idx)
    );

    always_comb begin
        outst_d = outst_q;
        if (fire && !rsp_ok) begin
            outst_d = outst_q + 3'd1;
        end else if (!fire && rsp_ok) begin
            outst_d = outst_q - 3'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        rspi_d     = rspi_q;
        pass_d     = pass_q;
        sel_d      = sel_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        fix_d      = fix_q;
        fen_d      = fen_q;
        total_d    = total_q;
        perr_d     = perr_q;
        clear_best = 1'b0;
        old_c      = (sel_q == SEL_C1) ? c1_q : c2_q;
        converged  = (pass_q >= 4'd2) && (best_idx == old_c);

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    c1_d       = '0;
                    c2_d       = '0;
                    total_d    = '0;
                    perr_d     = 1'b0;
                    pass_d     = '0;
                    sel_d      = SEL_C1;
                    fix_d      = '0;
                    fen_d      = 1'b0;
                    issue_d    = '0;
                    rspi_d     = '0;
                    clear_best = 1'b1;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (fire) begin
                    issue_d = issue_q + IW'(1);
                end
                if (rsp_ok) begin
                    rspi_d = rspi_q + IW'(1);
                    if (rspi_q == IDX_LAST) begin
                        state_d = ST_PASS_END;
                    end
                end
            end
            ST_PASS_END: begin
                if (sel_q == SEL_C1) begin
                    c1_d = best_idx;
                end else begin
                    c2_d = best_idx;
                end
                total_d = best_cnt;
                if (converged || (pass_q == LAST_PASS)) begin
                    state_d = ST_FIN;
                end else begin
                    // The circle that just moved becomes the fixed one for the next sweep.
                    pass_d     = pass_q + 4'd1;
                    sel_d      = ~sel_q;
                    fix_d      = best_idx;
                    fen_d      = 1'b1;
                    issue_d    = '0;
                    rspi_d     = '0;
                    clear_best = 1'b1;
                    state_d    = ST_SCAN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stray) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            issue_q <= '0;
            rspi_q  <= '0;
            outst_q <= '0;
            pass_q  <= '0;
            sel_q   <= SEL_C1;
            c1_q    <= '0;
            c2_q    <= '0;
            fix_q   <= '0;
            fen_q   <= 1'b0;
            total_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            rspi_q  <= rspi_d;
            outst_q <= outst_d;
            pass_q  <= pass_d;
            sel_q   <= sel_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            fix_q   <= fix_d;
            fen_q   <= fen_d;
            total_q <= total_d;
            perr_q  <= perr_d;
        end
    end

    assign REQ_VALID = req_valid;
    assign REQ_CX    = issue_q[CW-1:0];
    assign REQ_CY    = issue_q[2*CW-1:CW];
    assign REQ_FEN   = fen_q;
    assign REQ_FX    = fix_q[CW-1:0];
    assign REQ_FY    = fix_q[2*CW-1:CW];
    assign C1X       = c1_q[CW-1:0];
    assign C1Y       = c1_q[2*CW-1:CW];
    assign C2X       = c2_q[CW-1:0];
    assign C2Y       = c2_q[2*CW-1:CW];
    assign TOTAL     = total_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_FIN);
    assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// tb/tb_laser_scan_ctrl.sv - randomized evaluator and pass-level reference model for laser_scan_ctrl
module tb_laser_scan_ctrl;

    localparam int MAX_OUT  = 4;
    localparam int MAX_PASS = 8;

    logic       CLK       = 1'b0;
    logic       RST       = 1'b1;
    logic       START     = 1'b0;
    logic       REQ_READY = 1'b0;
    logic       RSP_VALID = 1'b0;
    logic [5:0] RSP_CNT   = 6'd0;
    logic       REQ_VALID, REQ_FEN, BUSY, DONE, PROTO_ERR;
    logic [3:0] REQ_CX, REQ_CY, REQ_FX, REQ_FY, C1X, C1Y, C2X, C2Y;
    logic [5:0] TOTAL;

    laser_scan_ctrl #(.CW(4), .NW(6), .MAX_OUT(MAX_OUT), .MAX_PASS(MAX_PASS)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CX(REQ_CX), .REQ_CY(REQ_CY), .REQ_FEN(REQ_FEN), .REQ_FX(REQ_FX), .REQ_FY(REQ_FY),
        .RSP_VALID(RSP_VALID), .RSP_CNT(RSP_CNT),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .TOTAL(TOTAL), .BUSY(BUSY), .DONE(DONE), .PROTO_ERR(PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int cnt;
    } pend_t;

    pend_t       pend[$];
    int          tbl[256];
    int          ev_mode = 0;
    int          ev_lat = 1;
    int          ev_rdy = 0;
    bit          force_rsp = 1'b0;
    int          cyc = 0;
    int          fires = 0;
    int          out_viol = 0;
    int          stall_viol = 0;
    int          done_seen = 0;
    bit          prev_stall = 1'b0;
    logic [16:0] saved = '0;

    int n_total = 0;
    int n_bad = 0;
    int exp_c1, exp_c2, exp_total, exp_passes;

    function automatic int eval_cnt(int mode, int idx, bit fen, int fix);
        case (mode)
            0: return idx & 63;
            1: return 5;
            2: begin
                if (!fen) return (idx == 0) ? 10 : 1;
                return (idx == ((fix + 1) & 255)) ? 10 : 1;
            end
            default: return fen ? tbl[(idx ^ fix) & 255] : tbl[idx];
        endcase
    endfunction

    // Whole-pass model: score every centre, keep the last maximum, alternate circles.
    task automatic model_job(input int mode);
        int c[2];
        int mv, fix, p, best_c, best_i, old, v;
        bit fen;
        c[0] = 0; c[1] = 0; mv = 0; fix = 0; fen = 1'b0; p = 0;
        forever begin
            best_c = -1;
            best_i = 0;
            for (int i = 0; i < 256; i++) begin
                v = eval_cnt(mode, i, fen, fix);
                if (v >= best_c) begin
                    best_c = v;
                    best_i = i;
                end
            end
            old = c[mv];
            c[mv] = best_i;
            exp_total = best_c;
            exp_passes = p + 1;
            if ((p >= 2 && best_i == old) || p == MAX_PASS - 1) break;
            fix = best_i;
            fen = 1'b1;
            mv = 1 - mv;
            p++;
        end
        exp_c1 = c[0];
        exp_c2 = c[1];
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (DONE === 1'b1) done_seen++;
        if (RST) prev_stall = 1'b0;
        if (prev_stall && ({REQ_CX, REQ_CY, REQ_FEN, REQ_FX, REQ_FY} !== saved)) stall_viol++;
        RSP_VALID = 1'b0;
        RSP_CNT = 6'd0;
        if (force_rsp) begin
            RSP_VALID = 1'b1;
            RSP_CNT = 6'h2a;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            RSP_VALID = 1'b1;
            RSP_CNT = 6'(pend[0].cnt);
            void'(pend.pop_front());
        end
        case (ev_rdy)
            0: REQ_READY = 1'b1;
            1: REQ_READY = ~REQ_READY;
            default: REQ_READY = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (REQ_VALID === 1'b1 && REQ_READY) begin
            pend.push_back('{cyc + ev_lat,
                eval_cnt(ev_mode, int'({REQ_CY, REQ_CX}), REQ_FEN, int'({REQ_FY, REQ_FX}))});
            fires++;
            if (pend.size() > MAX_OUT) out_viol++;
        end
        prev_stall = (REQ_VALID === 1'b1) && !REQ_READY;
        saved = {REQ_CX, REQ_CY, REQ_FEN, REQ_FX, REQ_FY};
    end

    task automatic drain();
        int n = 0;
        while (pend.size() != 0 && n < 100) begin
            @(negedge CLK); #2;
            n++;
        end
    endtask

    task automatic run_job(input string name, input int mode, input int lat, input int rdy);
        int d0, f0, o0, s0, n;
        drain();
        ev_mode = mode; ev_lat = lat; ev_rdy = rdy;
        model_job(mode);
        d0 = done_seen; f0 = fires; o0 = out_viol; s0 = stall_viol;
        START = 1'b1;
        @(negedge CLK); #2;
        START = 1'b0;
        n_total++;
        if (PROTO_ERR !== 1'b0 || BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_start: busy=%b proto_err=%b want busy=1 proto_err=0", name, BUSY, PROTO_ERR);
        end
        n = 0;
        while (DONE !== 1'b1 && n < 8000) begin
            @(negedge CLK); #2;
            n++;
        end
        n_total++;
        if (DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: done=%b after %0d cycles want 1", name, DONE, n);
        end
        n_total++;
        if (BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy_at_done: busy=%b want 1", name, BUSY);
        end
        @(negedge CLK); #2;
        n_total++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after_done: done=%b busy=%b want 0/0", name, DONE, BUSY);
        end
        n_total++;
        if (int'(C1X) !== (exp_c1 & 15) || int'(C1Y) !== (exp_c1 >> 4)) begin
            n_bad++;
            $display("FAIL %s_c1: got (%0d,%0d) want (%0d,%0d)", name, C1X, C1Y, exp_c1 & 15, exp_c1 >> 4);
        end
        n_total++;
        if (int'(C2X) !== (exp_c2 & 15) || int'(C2Y) !== (exp_c2 >> 4)) begin
            n_bad++;
            $display("FAIL %s_c2: got (%0d,%0d) want (%0d,%0d)", name, C2X, C2Y, exp_c2 & 15, exp_c2 >> 4);
        end
        n_total++;
        if (int'(TOTAL) !== exp_total) begin
            n_bad++;
            $display("FAIL %s_total: got %0d want %0d", name, TOTAL, exp_total);
        end
        n_total++;
        if (fires - f0 !== exp_passes * 256) begin
            n_bad++;
            $display("FAIL %s_requests: got %0d want %0d", name, fires - f0, exp_passes * 256);
        end
        repeat (4) @(negedge CLK);
        #2;
        n_total++;
        if (done_seen - d0 !== 1) begin
            n_bad++;
            $display("FAIL %s_done_pulses: got %0d want 1", name, done_seen - d0);
        end
        n_total++;
        if (out_viol - o0 !== 0 || stall_viol - s0 !== 0) begin
            n_bad++;
            $display("FAIL %s_handshake: outstanding_over=%0d unstable_stall=%0d want 0/0",
                     name, out_viol - o0, stall_viol - s0);
        end
        n_total++;
        if (PROTO_ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_proto_err: got %b want 0", name, PROTO_ERR);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #2;
        n_total++;
        if ({REQ_VALID, BUSY, DONE, PROTO_ERR, REQ_FEN} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: valid/busy/done/perr/fen=%b want 00000",
                     {REQ_VALID, BUSY, DONE, PROTO_ERR, REQ_FEN});
        end
        n_total++;
        if ({C1X, C1Y, C2X, C2Y, TOTAL, REQ_CX, REQ_CY, REQ_FX, REQ_FY} !== 38'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {C1X, C1Y, C2X, C2Y, TOTAL, REQ_CX, REQ_CY, REQ_FX, REQ_FY});
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        n_total++;
        if (BUSY !== 1'b0 || REQ_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b valid=%b want 0/0", BUSY, REQ_VALID);
        end
    endtask

    task automatic test_idx_pattern();
        run_job("idx", 0, 1, 0);
        n_total++;
        if (exp_passes != 3 || {C1X, C1Y} !== 8'hff || TOTAL !== 6'h3f) begin
            n_bad++;
            $display("FAIL idx_fixed: c1=(%0d,%0d) total=%0d want (15,15) 63", C1X, C1Y, TOTAL);
        end
    endtask

    task automatic test_constant();
        run_job("const", 1, 1, 0);
        n_total++;
        if ({C1X, C1Y, C2X, C2Y} !== 16'hffff || TOTAL !== 6'd5) begin
            n_bad++;
            $display("FAIL const_fixed: c1=(%0d,%0d) c2=(%0d,%0d) total=%0d want all 15, 5",
                     C1X, C1Y, C2X, C2Y, TOTAL);
        end
    endtask

    task automatic test_stall();
        run_job("stall", 0, 3, 1);
    endtask

    task automatic test_no_converge();
        run_job("noconv", 2, 1, 0);
        n_total++;
        if (exp_passes != MAX_PASS || {C1X, C1Y, C2X, C2Y} !== 16'h6070 || TOTAL !== 6'd10) begin
            n_bad++;
            $display("FAIL noconv_fixed: c1=(%0d,%0d) c2=(%0d,%0d) total=%0d want (6,0) (7,0) 10",
                     C1X, C1Y, C2X, C2Y, TOTAL);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++) tbl[i] = int'($urandom_range(0, 63));
            run_job("rand", 3, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_stray();
        force_rsp = 1'b1;
        @(negedge CLK); #2;
        force_rsp = 1'b0;
        @(negedge CLK); #2;
        n_total++;
        if (PROTO_ERR !== 1'b1 || BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_idle: proto_err=%b busy=%b want 1/0", PROTO_ERR, BUSY);
        end
        run_job("stray_recover", 1, 1, 0);
    endtask

    task automatic test_reset_mid();
        int n, d0;
        drain();
        ev_mode = 0; ev_lat = 6; ev_rdy = 2;
        START = 1'b1;
        @(negedge CLK); #2;
        START = 1'b0;
        n = 0;
        while (!(REQ_FEN === 1'b1 && pend.size() >= 2) && n < 4000) begin
            @(negedge CLK); #2;
            n++;
        end
        n_total++;
        if (REQ_FEN !== 1'b1 || pend.size() < 2) begin
            n_bad++;
            $display("FAIL rstmid_reach: fen=%b outstanding=%0d want 1, >=2", REQ_FEN, pend.size());
        end
        d0 = done_seen;
        RST = 1'b1;
        #1;
        n_total++;
        if ({REQ_VALID, BUSY, DONE, PROTO_ERR, REQ_FEN, C1X, C1Y, C2X, C2Y, TOTAL,
             REQ_CX, REQ_CY, REQ_FX, REQ_FY} !== 43'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %h want 0", {REQ_VALID, BUSY, DONE, PROTO_ERR, REQ_FEN,
                     C1X, C1Y, C2X, C2Y, TOTAL, REQ_CX, REQ_CY, REQ_FX, REQ_FY});
        end
        @(negedge CLK); #2;
        RST = 1'b0;
        drain();
        repeat (3) @(negedge CLK);
        #2;
        n_total++;
        if (PROTO_ERR !== 1'b1 || BUSY !== 1'b0 || REQ_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_stray: proto_err=%b busy=%b valid=%b want 1/0/0", PROTO_ERR, BUSY, REQ_VALID);
        end
        n_total++;
        if (done_seen - d0 !== 0) begin
            n_bad++;
            $display("FAIL rstmid_done: got %0d pulses want 0", done_seen - d0);
        end
        for (int i = 0; i < 256; i++) tbl[i] = int'($urandom_range(0, 63));
        run_job("post_reset", 3, 2, 2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = 0;
        test_reset();
        test_idx_pattern();
        test_constant();
        test_stall();
        test_no_converge();
        test_random();
        test_stray();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
